// File: rtl/spike_raster_packer_if.sv
// Spike raster packer bus: spike/tick/flush control plus FWFT FIFO read port and status.
interface spike_raster_packer_if #(
    parameter int unsigned DEPTH_LOG2 = 10
);
    logic                  spike_in;
    logic                  tick;
    logic                  flush;
    logic                  rd_en;
    logic [15:0]           dout;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  underflow;
    logic [15:0]           drop_cnt;

    modport master (
        output spike_in, tick, flush, rd_en,
        input  dout, empty, full, level, overflow, underflow, drop_cnt
    );

    modport slave (
        input  spike_in, tick, flush, rd_en,
        output dout, empty, full, level, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/spike_raster_packer.sv
// Packs one spike bit per timestep into 16-bit words and queues them in a FWFT FIFO.
module spike_raster_packer #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input logic                  clk,
    input logic                  reset,
    spike_raster_packer_if.slave bus
);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             pending_q, pending_d;
    logic [3:0]       slot_q, slot_d;
    logic [15:0]      word_q, word_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             empty_c;
    logic             full_c;
    logic             push_c;
    logic             pop_c;
    logic             write_c;
    logic [15:0]      tick_word_c;
    logic [15:0]      push_word_c;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

    // Next-state: raster accumulation, push decision and FIFO pointer/flag updates
    always_comb begin
        pending_d   = pending_q;
        slot_d      = slot_q;
        word_d      = word_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        drop_cnt_d  = drop_cnt_q;

        // A spike in the tick cycle itself still belongs to the closing timestep
        tick_word_c = word_q | (16'(pending_q | bus.spike_in) << slot_q);
        push_word_c = bus.tick ? tick_word_c : word_q;
        // Tick+flush at slot 0 still pushes: the tick bit lands first, making slot non-zero
        push_c      = (bus.tick && (slot_q == 4'd15)) ||
                      (bus.flush && ((slot_q != 4'd0) || bus.tick));
        pop_c       = bus.rd_en && !empty_c;
        // Concurrent pop frees the head slot, so a push while full still fits
        write_c     = push_c && (!full_c || pop_c);

        if (bus.tick) begin
            pending_d = 1'b0;
            slot_d    = slot_q + 4'd1;
            word_d    = tick_word_c;
        end else if (bus.spike_in) begin
            pending_d = 1'b1;
        end

        if (push_c) begin
            slot_d = 4'd0;
            word_d = 16'h0000;
        end

        if (write_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (push_c) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (bus.rd_en) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 1'b0;
            slot_q      <= 4'd0;
            word_q      <= 16'h0000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= 16'h0000;
        end else begin
            pending_q   <= pending_d;
            slot_q      <= slot_d;
            word_q      <= word_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until written, pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && write_c) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= push_word_c;
        end
    end

    assign bus.dout      = empty_c ? 16'h0000 : mem_q[rd_ptr_q[PTR_W-2:0]];
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;
    assign bus.level     = wr_ptr_q - rd_ptr_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_spike_raster_packer.sv
// Scoreboard bench for spike_raster_packer with a 4-word FIFO.
module tb_spike_raster_packer;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic reset;

    spike_raster_packer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus();

    spike_raster_packer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [15:0] sb [$];
    logic        m_pend;
    logic [3:0]  m_slot;
    logic [15:0] m_word;
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pend = 1'b0;
        m_slot = 4'd0;
        m_word = 16'h0000;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_drop = 16'h0000;
    endtask

    task automatic chk_status();
        chk("level",     32'(bus.level),     32'(sb.size()));
        chk("empty",     32'(bus.empty),     32'(sb.size() == 0));
        chk("full",      32'(bus.full),      32'(sb.size() == DEPTH));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
        chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    endtask

    // One clock cycle: compare head word, drive inputs, advance model, check status
    task automatic cyc(input logic s, input logic t, input logic f, input logic r);
        logic        b;
        logic        push;
        logic        was_full;
        logic        pop;
        logic [15:0] w;
        @(negedge clk);
        chk("dout", 32'(bus.dout), 32'((sb.size() != 0) ? sb[0] : 16'h0000));
        bus.spike_in = s;
        bus.tick     = t;
        bus.flush    = f;
        bus.rd_en    = r;

        b = m_pend | s;
        w = m_word;
        if (t) w = w | (16'(b) << m_slot);
        push     = (t && (m_slot == 4'd15)) || (f && ((m_slot != 4'd0) || t));
        was_full = (sb.size() == DEPTH);
        pop      = r && (sb.size() != 0);
        if (r && !pop) m_unf = 1'b1;
        if (pop) void'(sb.pop_front());
        if (push) begin
            if (was_full && !pop) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else begin
                sb.push_back(w);
            end
        end
        m_pend = t ? 1'b0 : (m_pend | s);
        m_slot = push ? 4'd0 : (t ? m_slot + 4'd1 : m_slot);
        m_word = push ? 16'h0000 : w;

        @(posedge clk);
        #1;
        chk_status();
    endtask

    // Reset with control inputs asserted to show reset dominates
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.spike_in = 1'b1;
        bus.tick     = 1'b1;
        bus.flush    = 1'b1;
        bus.rd_en    = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset        = 1'b0;
        bus.spike_in = 1'b0;
        bus.tick     = 1'b0;
        bus.flush    = 1'b0;
        bus.rd_en    = 1'b0;
        chk_status();
        chk("rst_dout", 32'(bus.dout), 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (sb.size() != 0) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.spike_in = 1'b0;
        bus.tick     = 1'b0;
        bus.flush    = 1'b0;
        bus.rd_en    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Spikes in timesteps 0, 3, 15 over 16 ticks
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc((i == 0) || (i == 3) || (i == 15), 1'b1, 1'b0, 1'b0);
        end
        chk("w8009_dout",  32'(bus.dout),  32'h8009);
        chk("w8009_level", 32'(bus.level), 32'd1);
        chk("w8009_empty", 32'(bus.empty), 32'd0);
        drain();

        // Multi-cycle pulse between ticks latches; next quiet timestep stays 0
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pulse_word", 32'(bus.dout), 32'h0001);
        drain();

        // 5 ticks with spikes in timesteps 0 and 4, then flush twice
        for (int i = 0; i < 5; i++) cyc((i == 0) || (i == 4), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_word",  32'(bus.dout),  32'h0011);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush2_level", 32'(bus.level), 32'd1);
        drain();

        // Tick and flush together at slot 0 push exactly one word
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("tf_slot0_level", 32'(bus.level), 32'd1);
        chk("tf_slot0_word",  32'(bus.dout),  32'h0001);
        drain();

        // Six words into a 4-deep FIFO without reads: two dropped
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < k; j++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk("ovf_full",  32'(bus.full),     32'd1);
        chk("ovf_level", 32'(bus.level),    32'd4);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_drops", 32'(bus.drop_cnt), 32'd2);
        chk("ovf_head",  32'(bus.dout),     32'h0001);

        // Push and read together while full: no drop, head advances
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("fullrw_level", 32'(bus.level),    32'd4);
        chk("fullrw_head",  32'(bus.dout),     32'h0003);
        chk("fullrw_drops", 32'(bus.drop_cnt), 32'd2);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("unf_flag", 32'(bus.underflow), 32'd1);
        chk("unf_dout", 32'(bus.dout),      32'h0000);

        // Reset mid-operation with level 3 and slot 7
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (7) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd3);
        do_reset();
        chk("rst_empty", 32'(bus.empty),    32'd1);
        chk("rst_level", 32'(bus.level),    32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        chk("rst_drops", 32'(bus.drop_cnt), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_slot0_flush", 32'(bus.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
